adder_arbiter: RTL and testbench

Round-robin scheduler that shares one single-precision `adder` instance between `N` requesters. Each requester hands over an operand pair with a stb/ack handshake. The arbiter feeds the operands to the adder's `a`/`b` ports in sequence, collects `z`, and returns it to the requester that was granted. It sits between the requester clients and the shared adder in the floating-point cluster, and serialises all adds onto one FPU.

---
 rtl/adder_arbiter_if.sv | 40 ++++
 rtl/adder_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_adder_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_arbiter_if.sv
// Requester and shared-adder handshake bundle for adder_arbiter.
interface adder_arbiter_if #(
  parameter int unsigned N = 4
);
  // Requester side: operand pairs in, results out
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]    req_stb;
  logic [N-1:0]    req_ack;
  logic [31:0]     res_z;
  logic [N-1:0]    res_stb;
  logic [N-1:0]    res_ack;

  // Shared adder side
  logic [31:0]     adder_a;
  logic            adder_a_stb;
  logic            adder_a_ack;
  logic [31:0]     adder_b;
  logic            adder_b_stb;
  logic            adder_b_ack;
  logic [31:0]     adder_z;
  logic            adder_z_stb;
  logic            adder_z_ack;

  // Clients plus the adder: everything the arbiter does not drive
  modport master (
    output req_a, req_b, req_stb, res_ack,
    output adder_a_ack, adder_b_ack, adder_z, adder_z_stb,
    input  req_ack, res_z, res_stb,
    input  adder_a, adder_a_stb, adder_b, adder_b_stb, adder_z_ack
  );

  // The arbiter itself
  modport slave (
    input  req_a, req_b, req_stb, res_ack,
    input  adder_a_ack, adder_b_ack, adder_z, adder_z_stb,
    output req_ack, res_z, res_stb,
    output adder_a, adder_a_stb, adder_b, adder_b_stb, adder_z_ack
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter serialising N requesters onto one shared adder.
module adder_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned GW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  adder_arbiter_if.slave  bus,
  output logic            busy,
  output logic [GW-1:0]   grant_id,
  output logic [15:0]     ops_done
);

  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {
    ST_IDLE, ST_GRANT, ST_SEND_A, ST_SEND_B, ST_WAIT_Z, ST_RETURN
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [N-1:0]    req_ack_q, req_ack_d;
  logic [N-1:0]    res_stb_q, res_stb_d;
  logic [DW-1:0]   res_z_q, res_z_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic            a_stb_q, a_stb_d;
  logic            b_stb_q, b_stb_d;
  logic            z_ack_q, z_ack_d;
  logic            busy_q, busy_d;
  logic [15:0]     ops_q, ops_d;

  logic [N-1:0]    win_mask;
  logic [GW-1:0]   win_id;
  logic            found;
  logic [N-1:0]    gmask;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;

  // Winner search from ptr upward with wrap, plus decode of the held grant
  always_comb begin
    win_mask = '0;
    win_id   = '0;
    found    = 1'b0;
    gmask    = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (!found && bus.req_stb[i] && (GW'(i) >= ptr_q)) begin
        found       = 1'b1;
        win_id      = GW'(i);
        win_mask[i] = 1'b1;
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!found && bus.req_stb[i] && (GW'(i) < ptr_q)) begin
        found       = 1'b1;
        win_id      = GW'(i);
        win_mask[i] = 1'b1;
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      gmask[i] = (grant_q == GW'(i));
      if (gmask[i]) begin
        sel_a = bus.req_a[DW*i +: DW];
        sel_b = bus.req_b[DW*i +: DW];
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      req_ack_q <= '0;
      res_stb_q <= '0;
      res_z_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      a_stb_q   <= 1'b0;
      b_stb_q   <= 1'b0;
      z_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
      ops_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      req_ack_q <= req_ack_d;
      res_stb_q <= res_stb_d;
      res_z_q   <= res_z_d;
      a_q       <= a_d;
      b_q       <= b_d;
      a_stb_q   <= a_stb_d;
      b_stb_q   <= b_stb_d;
      z_ack_q   <= z_ack_d;
      busy_q    <= busy_d;
      ops_q     <= ops_d;
    end
  end

  // Next state and next register values; one transaction in flight at a time
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    req_ack_d = req_ack_q;
    res_stb_d = res_stb_q;
    res_z_d   = res_z_q;
    a_d       = a_q;
    b_d       = b_q;
    a_stb_d   = a_stb_q;
    b_stb_d   = b_stb_q;
    z_ack_d   = z_ack_q;
    ops_d     = ops_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req_stb) begin
          grant_d   = win_id;
          req_ack_d = win_mask;
          state_d   = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A dropped req_stb here simply stalls; the grant is never reselected
        if (|(bus.req_stb & req_ack_q & gmask)) begin
          a_d       = sel_a;
          b_d       = sel_b;
          req_ack_d = '0;
          a_stb_d   = 1'b1;
          state_d   = ST_SEND_A;
        end
      end
      ST_SEND_A: begin
        if (a_stb_q && bus.adder_a_ack) begin
          a_stb_d = 1'b0;
          b_stb_d = 1'b1;
          state_d = ST_SEND_B;
        end
      end
      ST_SEND_B: begin
        if (b_stb_q && bus.adder_b_ack) begin
          b_stb_d = 1'b0;
          z_ack_d = 1'b1;
          state_d = ST_WAIT_Z;
        end
      end
      ST_WAIT_Z: begin
        if (z_ack_q && bus.adder_z_stb) begin
          res_z_d   = bus.adder_z;
          z_ack_d   = 1'b0;
          res_stb_d = gmask;
          state_d   = ST_RETURN;
        end
      end
      ST_RETURN: begin
        if (|(res_stb_q & bus.res_ack)) begin
          res_stb_d = '0;
          ops_d     = ops_q + 16'd1;
          ptr_d     = (grant_q == GW'(N - 1)) ? '0 : grant_q + GW'(1);
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign bus.req_ack     = req_ack_q;
  assign bus.res_stb     = res_stb_q;
  assign bus.res_z       = res_z_q;
  assign bus.adder_a     = a_q;
  assign bus.adder_b     = b_q;
  assign bus.adder_a_stb = a_stb_q;
  assign bus.adder_b_stb = b_stb_q;
  assign bus.adder_z_ack = z_ack_q;
  assign busy            = busy_q;
  assign grant_id        = grant_q;
  assign ops_done        = ops_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with requester agents and a stand-in adder.
module tb_adder_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned GW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy;
  logic [GW-1:0] grant_id;
  logic [15:0]   ops_done;

  int            checks = 0;
  int            errors = 0;
  logic [N-1:0]  res_hold;
  int            ack_cnt [N];
  int            log_id [$];
  logic [31:0]   log_z [$];
  logic [GW-1:0] log_gid [$];

  adder_arbiter_if #(.N(N)) bus ();

  adder_arbiter #(.N(N), .GW(GW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id),
    .ops_done (ops_done)
  );

  initial forever #5 clk = ~clk;

  // Stand-in adder: two known float sums, otherwise an integer sum as a tag
  function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h7F800000 && b == 32'hFF800000) return 32'hFFC00000;
    return a + b;
  endfunction

  // Requesters: drop stb once acked, ack results unless held, log every result
  task automatic agent();
    logic [N-1:0]  racc;
    logic [N-1:0]  rhs;
    logic [31:0]   rz;
    logic [GW-1:0] gid;
    forever begin
      @(posedge clk);
      racc = bus.req_stb & bus.req_ack;
      rhs  = bus.res_stb & bus.res_ack;
      rz   = bus.res_z;
      gid  = grant_id;
      #1;
      bus.req_stb = bus.req_stb & ~racc;
      for (int i = 0; i < int'(N); i++) begin
        if (racc[i]) ack_cnt[i]++;
        if (rhs[i]) begin
          log_id.push_back(i);
          log_z.push_back(rz);
          log_gid.push_back(gid);
        end
      end
      bus.res_ack = bus.res_stb & ~res_hold;
    end
  endtask

  // Adder: always accepts operands, answers three cycles after operand B
  task automatic adder_model();
    logic        a_hs, b_hs, z_hs;
    logic [31:0] av, bv, cap_a, cap_b;
    int          cnt;
    cnt = 0;
    cap_a = '0;
    cap_b = '0;
    bus.adder_a_ack = 1'b1;
    bus.adder_b_ack = 1'b1;
    bus.adder_z_stb = 1'b0;
    bus.adder_z     = '0;
    forever begin
      @(posedge clk);
      a_hs = bus.adder_a_stb & bus.adder_a_ack;
      b_hs = bus.adder_b_stb & bus.adder_b_ack;
      z_hs = bus.adder_z_stb & bus.adder_z_ack;
      av   = bus.adder_a;
      bv   = bus.adder_b;
      #1;
      if (!rst_n) begin
        bus.adder_z_stb = 1'b0;
        cnt = 0;
      end else begin
        if (a_hs) cap_a = av;
        if (z_hs) bus.adder_z_stb = 1'b0;
        if (b_hs) begin
          cap_b = bv;
          cnt = 3;
        end else if (cnt > 1) begin
          cnt--;
        end else if (cnt == 1) begin
          bus.adder_z     = fake_add(cap_a, cap_b);
          bus.adder_z_stb = 1'b1;
          cnt = 0;
        end
      end
    end
  endtask

  task automatic raise(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
    bus.req_stb[i] = 1'b1;
  endtask

  task automatic clear_log();
    log_id.delete();
    log_z.delete();
    log_gid.delete();
    for (int i = 0; i < int'(N); i++) ack_cnt[i] = 0;
  endtask

  task automatic wait_ops(input logic [15:0] target, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (ops_done == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, bus.adder_a_stb, bus.adder_b_stb, bus.adder_z_ack} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000",
               {busy, bus.adder_a_stb, bus.adder_b_stb, bus.adder_z_ack});
    end
    checks++;
    if ({bus.req_ack, bus.res_stb} !== 8'h00) begin
      errors++;
      $display("FAIL reset_stb: got %h expected 00", {bus.req_ack, bus.res_stb});
    end
    checks++;
    if ({grant_id, ops_done} !== 19'h0) begin
      errors++;
      $display("FAIL reset_count: got %h expected 0", {grant_id, ops_done});
    end
    checks++;
    if ({bus.res_z, bus.adder_a, bus.adder_b} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {bus.res_z, bus.adder_a, bus.adder_b});
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_log();
    @(negedge clk);
    raise(0, 32'h3F800000, 32'h40000000);
    @(negedge clk);
    checks++;
    if ({busy, bus.req_ack} !== 5'b1_0001) begin
      errors++;
      $display("FAIL single_grant: got %b expected 10001", {busy, bus.req_ack});
    end
    wait_ops(16'd1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_timeout: got ops_done %0d expected 1", ops_done);
    end
    checks++;
    if (log_id.size() != 1) begin
      errors++;
      $display("FAIL single_count: got %0d results expected 1", log_id.size());
    end else begin
      checks++;
      if (log_id[0] != 0 || log_z[0] !== 32'h40400000) begin
        errors++;
        $display("FAIL single_result: got id %0d z %h expected id 0 z 40400000", log_id[0], log_z[0]);
      end
    end
    checks++;
    if (ack_cnt[0] != 1) begin
      errors++;
      $display("FAIL single_ack_once: got %0d acks expected 1", ack_cnt[0]);
    end
    @(negedge clk);
    checks++;
    if ({busy, bus.res_stb} !== 5'b0) begin
      errors++;
      $display("FAIL single_idle: got %b expected 00000", {busy, bus.res_stb});
    end
  endtask

  task automatic test_all_four();
    bit ok;
    logic [31:0] exp_z [4];
    exp_z[0] = 32'h41000100;
    exp_z[1] = 32'h41000201;
    exp_z[2] = 32'h41000302;
    exp_z[3] = 32'h41000403;
    do_reset();
    clear_log();
    @(negedge clk);
    for (int i = 0; i < 4; i++) raise(i, 32'h41000000 + 32'(i), 32'h00000100 * 32'(i + 1));
    wait_ops(16'd4, ok);
    checks++;
    if (!ok || log_id.size() != 4) begin
      errors++;
      $display("FAIL four_count: got %0d results ops %0d expected 4", log_id.size(), ops_done);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_id[i] != i || log_gid[i] !== GW'(i) || log_z[i] !== exp_z[i]) begin
          errors++;
          $display("FAIL four_order_%0d: got id %0d gid %0d z %h expected id %0d z %h",
                   i, log_id[i], log_gid[i], log_z[i], i, exp_z[i]);
        end
      end
    end
  endtask

  task automatic test_rotation();
    bit ok;
    int          exp_id [3];
    logic [31:0] exp_z [3];
    exp_id[0] = 1; exp_id[1] = 0; exp_id[2] = 1;
    exp_z[0] = 32'h3; exp_z[1] = 32'h30; exp_z[2] = 32'h300;
    clear_log();
    @(negedge clk);
    raise(1, 32'h1, 32'h2);
    wait_ops(16'd5, ok);
    @(negedge clk);
    raise(0, 32'h10, 32'h20);
    raise(1, 32'h100, 32'h200);
    wait_ops(16'd7, ok);
    checks++;
    if (!ok || log_id.size() != 3) begin
      errors++;
      $display("FAIL rot_count: got %0d results ops %0d expected 3", log_id.size(), ops_done);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (log_id[i] != exp_id[i] || log_z[i] !== exp_z[i]) begin
          errors++;
          $display("FAIL rot_order_%0d: got id %0d z %h expected id %0d z %h",
                   i, log_id[i], log_z[i], exp_id[i], exp_z[i]);
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    bit ok;
    bit seen;
    clear_log();
    res_hold = 4'b0100;
    @(negedge clk);
    raise(2, 32'h1000, 32'h2000);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = bus.res_stb[2];
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL hold_res_stb: got res_stb %b expected 0100", bus.res_stb);
    end
    raise(3, 32'h5, 32'h6);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (bus.res_stb !== 4'b0100 || bus.res_z !== 32'h3000 || bus.req_ack !== 4'b0) begin
        errors++;
        $display("FAIL hold_stable_%0d: got res_stb %b z %h req_ack %b expected 0100 00003000 0000",
                 c, bus.res_stb, bus.res_z, bus.req_ack);
      end
    end
    res_hold = '0;
    wait_ops(16'd9, ok);
    checks++;
    if (!ok || log_id.size() != 2) begin
      errors++;
      $display("FAIL hold_count: got %0d results ops %0d expected 2", log_id.size(), ops_done);
    end else begin
      checks++;
      if (log_id[0] != 2 || log_z[0] !== 32'h3000 || log_id[1] != 3 || log_z[1] !== 32'hB) begin
        errors++;
        $display("FAIL hold_order: got %0d/%h %0d/%h expected 2/00003000 3/0000000b",
                 log_id[0], log_z[0], log_id[1], log_z[1]);
      end
    end
    checks++;
    if (ack_cnt[3] != 1) begin
      errors++;
      $display("FAIL hold_ack3: got %0d acks expected 1", ack_cnt[3]);
    end
  endtask

  task automatic test_inf();
    bit ok;
    clear_log();
    @(negedge clk);
    raise(0, 32'h7F800000, 32'hFF800000);
    wait_ops(16'd10, ok);
    checks++;
    if (!ok || log_id.size() != 1) begin
      errors++;
      $display("FAIL inf_count: got %0d results ops %0d expected 1", log_id.size(), ops_done);
    end else begin
      checks++;
      if (log_id[0] != 0 || log_z[0] !== 32'hFFC00000) begin
        errors++;
        $display("FAIL inf_result: got id %0d z %h expected id 0 z ffc00000", log_id[0], log_z[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    clear_log();
    @(negedge clk);
    raise(1, 32'h7, 32'h8);
    wait_ops(16'd11, ok);
    @(negedge clk);
    raise(1, 32'h9, 32'hA);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = bus.adder_z_ack;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_wait_z: got adder_z_ack 0 expected 1");
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({busy, bus.adder_a_stb, bus.adder_b_stb, bus.adder_z_ack, bus.req_ack, bus.res_stb} !== 12'h0) begin
      errors++;
      $display("FAIL mid_ctrl: got %h expected 000",
               {busy, bus.adder_a_stb, bus.adder_b_stb, bus.adder_z_ack, bus.req_ack, bus.res_stb});
    end
    checks++;
    if ({bus.res_z, bus.adder_a, bus.adder_b, grant_id, ops_done} !== 115'h0) begin
      errors++;
      $display("FAIL mid_data: got z %h a %h b %h gid %0d ops %0d expected all 0",
               bus.res_z, bus.adder_a, bus.adder_b, grant_id, ops_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (log_id.size() != 1) begin
      errors++;
      $display("FAIL mid_no_result: got %0d results expected 1", log_id.size());
    end
    raise(1, 32'h11, 32'h22);
    raise(3, 32'h33, 32'h44);
    wait_ops(16'd2, ok);
    checks++;
    if (!ok || log_id.size() != 3) begin
      errors++;
      $display("FAIL mid_count: got %0d results ops %0d expected 3", log_id.size(), ops_done);
    end else begin
      checks++;
      if (log_id[1] != 1 || log_z[1] !== 32'h33 || log_id[2] != 3 || log_z[2] !== 32'h77) begin
        errors++;
        $display("FAIL mid_order: got %0d/%h %0d/%h expected 1/00000033 3/00000077",
                 log_id[1], log_z[1], log_id[2], log_z[2]);
      end
    end
  endtask

  initial begin
    bus.req_stb = '0;
    bus.req_a   = '0;
    bus.req_b   = '0;
    bus.res_ack = '0;
    res_hold    = '0;
    for (int i = 0; i < int'(N); i++) ack_cnt[i] = 0;
    fork
      agent();
      adder_model();
    join_none
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_all_four();
    test_rotation();
    test_back_pressure();
    test_inf();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
